// File: rtl/axi4_lite_master_param_if.sv
`default_nettype none
// axi4_lite_master_param_if: the five AXI4-Lite channels, sized by address/data width.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi4_lite_master_param_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_master_param.sv
`default_nettype none
// axi4_lite_master_param: bridges a start/done command port onto AXI4-Lite, one transaction at a time.
// Optional watchdog built when AXI_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES).
module axi4_lite_master_param #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    AXI_Start,
  input  logic                    AXI_WriteEn,
  input  logic [ADDR_WIDTH-1:0]   AXI_Addr,
  input  logic [DATA_WIDTH-1:0]   AXI_WData,
  input  logic [DATA_WIDTH/8-1:0] AXI_WStrb,
  output logic                    AXI_Ready,
  output logic [DATA_WIDTH-1:0]   AXI_RData,
  output logic [1:0]              AXI_Resp,
  output logic                    AXI_Error,
  output logic                    AXI_Timeout,
  output logic                    AXI_Done,
  axi4_lite_master_param_if.master m_axi
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    error_q, error_d, done_q, done_d, ready_q;
  logic                    timeout_d;

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter is 0 in the first busy cycle, so expiry lands TIMEOUT_CYCLES cycles after accept.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    error_d   = error_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (AXI_Start) begin
          addr_d  = AXI_Addr;
          wdata_d = AXI_WData;
          wstrb_d = AXI_WStrb;
          if (AXI_WriteEn) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        awvalid_d = awvalid_q && !m_axi.awready;
        wvalid_d  = wvalid_q && !m_axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          resp_d   = m_axi.bresp;
          error_d  = m_axi.bresp[1];
          done_d   = 1'b1;
        end
      end
      RD_REQ: begin
        if (m_axi.arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_axi.rvalid) begin
          state_d  = IDLE;
          rready_d = 1'b0;
          rdata_d  = m_axi.rdata;
          resp_d   = m_axi.rresp;
          error_d  = m_axi.rresp[1];
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_TIMEOUT_EN
    // A completing handshake in the expiry cycle already leads to IDLE and takes priority.
    if (state_q != IDLE && state_d != IDLE && cnt_q == CNT_LAST) begin
      state_d   = IDLE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      resp_d    = 2'b10;
      error_d   = 1'b1;
      done_d    = 1'b1;
      timeout_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      error_q   <= error_d;
      done_q    <= done_d;
      ready_q   <= (state_d == IDLE);
    end
  end

`ifdef AXI_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)         timeout_q <= 1'b0;
    else if (done_d) timeout_q <= timeout_d;
  end
  assign AXI_Timeout = timeout_q;
`else
  assign AXI_Timeout = timeout_d;
`endif

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign AXI_Ready = ready_q;
  assign AXI_RData = rdata_q;
  assign AXI_Resp  = resp_q;
  assign AXI_Error = error_q;
  assign AXI_Done  = done_q;
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_param.sv
`default_nettype none
// tb_axi4_lite_master_param: randomized + directed bench with a memory-backed AXI slave
// and a scoreboard of expected completions predicted from the command stream.
module tb_axi4_lite_master_param;
  localparam int AW = 32;
  localparam int DW = 64;
`ifdef AXI_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  typedef struct {
    logic [1:0]  resp;
    logic        err;
    logic        tmo;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, write_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [7:0] wstrb = '0;
  logic ready, error, tmo, done;
  logic [DW-1:0] rdata;
  logic [1:0] resp;

  axi4_lite_master_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_master_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .AXI_Start(start), .AXI_WriteEn(write_en), .AXI_Addr(addr),
    .AXI_WData(wdata), .AXI_WStrb(wstrb), .AXI_Ready(ready), .AXI_RData(rdata),
    .AXI_Resp(resp), .AXI_Error(error), .AXI_Timeout(tmo), .AXI_Done(done), .m_axi(bus)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, done_cnt = 0, acc_cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [63:0] model_mem[logic [31:0]];
  logic [63:0] slv_mem[logic [31:0]];
  logic [63:0] model_rdata = '0;

  // slave configuration and observation
  bit cfg_rand = 0, stray = 0, stray_was = 0;
  int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  int aw_rise_cyc = 0, w_rise_cyc = 0, aw_hi = 0, w_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dflt(input logic [31:0] a);
    return {a, ~a};
  endfunction

  function automatic int pick(input int d);
    return cfg_rand ? int'($urandom_range(0, 3)) : d;
  endfunction

  // Reference model: memory with byte strobes, response code from address bits [13:12].
  function automatic void predict(input bit we, input logic [31:0] a, input logic [63:0] d,
                                  input logic [7:0] s, input bit abort);
    exp_t e;
    logic [63:0] w;
    e.tmo = 1'b0;
    e.resp = a[13:12];
    e.err = a[13];
    if (abort) begin
      e.resp = 2'b10; e.err = 1'b1; e.tmo = 1'b1;
    end else if (we) begin
      w = model_mem.exists(a) ? model_mem[a] : dflt(a);
      for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model_mem[a] = w;
    end else begin
      model_rdata = model_mem.exists(a) ? model_mem[a] : dflt(a);
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
  endfunction

  // Slave: all channels evaluated at negedge in one process so ordering is deterministic.
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit aw_hs_p, w_hs_p, ar_hs_p, b_hs_p, r_hs_p, aw_prev, w_prev;
  logic [31:0] aw_cap, ar_cap;
  logic [63:0] w_cap, tmpw;
  logic [7:0] ws_cap;
  logic [31:0] aw_q[$], ar_q[$], pa;
  logic [63:0] w_q[$];
  logic [7:0] ws_q[$];
  logic [1:0] b_q[$];

  task automatic slave_clear();
    bus.awready = 0; bus.wready = 0; bus.arready = 0; bus.bvalid = 0; bus.rvalid = 0;
    bus.bresp = 0; bus.rresp = 0; bus.rdata = 0;
    aw_wait = -1; w_wait = -1; ar_wait = -1; b_wait = -1; r_wait = -1;
    aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; b_hs_p = 0; r_hs_p = 0;
    aw_q.delete(); ar_q.delete(); w_q.delete(); ws_q.delete(); b_q.delete();
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin slave_clear(); continue; end
      if (stray) begin
        bus.awready = 1; bus.wready = 1; bus.arready = 1; bus.bvalid = 1; bus.rvalid = 1;
        stray_was = 1;
        continue;
      end
      if (stray_was) begin slave_clear(); stray_was = 0; end
      // AW
      if (aw_hs_p) begin aw_q.push_back(aw_cap); bus.awready = 0; aw_hs_p = 0; aw_wait = -1; end
      if (bus.awvalid && !aw_prev) begin aw_rise_cyc = cyc; aw_hi = 1; end
      else if (bus.awvalid) aw_hi++;
      aw_prev = bus.awvalid;
      if (!bus.awvalid) begin aw_wait = -1; bus.awready = 0; end
      else if (!bus.awready) begin
        if (aw_wait < 0) aw_wait = pick(cfg_aw_dly);
        if (aw_wait == 0) bus.awready = 1; else aw_wait--;
      end
      if (bus.awvalid && bus.awready) begin aw_hs_p = 1; aw_cap = bus.awaddr; end
      // W
      if (w_hs_p) begin w_q.push_back(w_cap); ws_q.push_back(ws_cap); bus.wready = 0; w_hs_p = 0; w_wait = -1; end
      if (bus.wvalid && !w_prev) begin w_rise_cyc = cyc; w_hi = 1; end
      else if (bus.wvalid) w_hi++;
      w_prev = bus.wvalid;
      if (!bus.wvalid) begin w_wait = -1; bus.wready = 0; end
      else if (!bus.wready) begin
        if (w_wait < 0) w_wait = pick(cfg_w_dly);
        if (w_wait == 0) bus.wready = 1; else w_wait--;
      end
      if (bus.wvalid && bus.wready) begin w_hs_p = 1; w_cap = bus.wdata; ws_cap = bus.wstrb; end
      // AR
      if (ar_hs_p) begin ar_q.push_back(ar_cap); bus.arready = 0; ar_hs_p = 0; ar_wait = -1; end
      if (!bus.arvalid) begin ar_wait = -1; bus.arready = 0; end
      else if (!bus.arready) begin
        if (ar_wait < 0) ar_wait = pick(cfg_ar_dly);
        if (ar_wait == 0) bus.arready = 1; else ar_wait--;
      end
      if (bus.arvalid && bus.arready) begin ar_hs_p = 1; ar_cap = bus.araddr; end
      // write commit once both address and data have been accepted
      while (aw_q.size() > 0 && w_q.size() > 0) begin
        pa = aw_q.pop_front();
        tmpw = slv_mem.exists(pa) ? slv_mem[pa] : dflt(pa);
        for (int b = 0; b < 8; b++) if (ws_q[0][b]) tmpw[8*b +: 8] = w_q[0][8*b +: 8];
        slv_mem[pa] = tmpw;
        void'(w_q.pop_front()); void'(ws_q.pop_front());
        b_q.push_back(pa[13:12]);
      end
      // B
      if (b_hs_p) begin bus.bvalid = 0; b_hs_p = 0; void'(b_q.pop_front()); b_wait = -1; end
      if (!bus.bvalid && b_q.size() > 0) begin
        if (b_wait < 0) b_wait = pick(cfg_b_dly);
        if (b_wait == 0) begin bus.bvalid = 1; bus.bresp = b_q[0]; end else b_wait--;
      end
      if (bus.bvalid && bus.bready) b_hs_p = 1;
      // R
      if (r_hs_p) begin bus.rvalid = 0; r_hs_p = 0; void'(ar_q.pop_front()); r_wait = -1; end
      if (!bus.rvalid && ar_q.size() > 0) begin
        if (r_wait < 0) r_wait = pick(cfg_r_dly);
        if (r_wait == 0) begin
          bus.rvalid = 1;
          bus.rdata = slv_mem.exists(ar_q[0]) ? slv_mem[ar_q[0]] : dflt(ar_q[0]);
          bus.rresp = ar_q[0][13:12];
        end else r_wait--;
      end
      if (bus.rvalid && bus.rready) r_hs_p = 1;
    end
  end

  // Scoreboard monitor: every completion pulse is matched against the oldest prediction.
  initial forever begin
    @(negedge clk);
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("resp", 64'(resp), 64'(mon_e.resp));
        check("error", 64'(error), 64'(mon_e.err));
        check("timeout", 64'(tmo), 64'(mon_e.tmo));
        check("rdata", rdata, mon_e.rdata);
        check("ready_with_done", 64'(ready), 64'd1);
      end
    end
  end

  task automatic issue(input bit we, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] s, input bit abort);
    if (!ready) check("issue_ready", 64'(ready), 64'd1);
    write_en = we; addr = a; wdata = d; wstrb = s; start = 1'b1; acc_cyc = cyc;
    predict(we, a, d, s, abort);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ready && n < 300) begin @(negedge clk); n++; end
    if (!ready) check("wait_idle_bound", 64'(ready), 64'd1);
  endtask

  task automatic preload(input logic [31:0] a, input logic [63:0] d);
    model_mem[a] = d;
    slv_mem[a] = d;
  endtask

  int d0;
  bit low_ok;
  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_resp_err_tmo", {61'd0, resp, error}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_valids", {59'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 64'd0);

    // zero-wait write: AW and W together one cycle after accept, done three cycles after accept
    issue(1, 32'h40, 64'hDEADBEEF, 8'h0F, 0);
    wait_idle();
    check("wr0_latency", 64'(cyc - acc_cyc), 64'd3);
    check("wr0_aw_rise", 64'(aw_rise_cyc - acc_cyc), 64'd1);
    check("wr0_w_rise", 64'(w_rise_cyc - acc_cyc), 64'd1);

    // AWREADY late, WREADY immediate: independent VALID lifetimes
    cfg_aw_dly = 2;
    issue(1, 32'h44, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    d0 = done_cnt;
    wait_idle();
    check("wr1_aw_hold", 64'(aw_hi), 64'd3);
    check("wr1_w_hold", 64'(w_hi), 64'd1);
    cfg_aw_dly = 0;

    // delayed read data, ready held low until completion
    preload(32'h80, 64'h12345678);
    cfg_r_dly = 5;
    d0 = done_cnt;
    issue(0, 32'h80, 64'd0, 8'd0, 0);
    low_ok = 1;
    for (int n = 0; n < 300 && !ready; n++) begin
      if (done) low_ok = 0;
      @(negedge clk);
    end
    check("rd0_ready_low", 64'(low_ok), 64'd1);
    check("rd0_latency", 64'(cyc - acc_cyc), 64'd8);
    @(negedge clk);
    check("rd0_single_done", 64'(done_cnt - d0), 64'd1);
    cfg_r_dly = 0;

    // error response on read, then a clean write leaves read data alone
    issue(0, 32'h3080, 64'd0, 8'd0, 0);
    wait_idle();
    issue(1, 32'h48, 64'hCAFE_F00D_0000_1111, 8'hA5, 0);
    wait_idle();

    // back-to-back with start held high; byte strobes limited to the low half
    write_en = 1; addr = 32'h50; wdata = 64'hFFEE_DDCC_BBAA_9988; wstrb = 8'h0F; start = 1;
    acc_cyc = cyc; predict(1, 32'h50, 64'hFFEE_DDCC_BBAA_9988, 8'h0F, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      wait_idle();
      check("b2b_done", 64'(done), 64'd1);
      if (i == 1) begin write_en = 0; addr = 32'h50; predict(0, 32'h50, 64'd0, 8'd0, 0); end
      else if (i == 2) begin
        write_en = 1; addr = 32'h54; wdata = 64'h1; wstrb = 8'h00;
        predict(1, 32'h54, 64'h1, 8'h00, 0);
      end else start = 0;
      if (i < 3) begin
        @(negedge clk);
        check("b2b_accepted", 64'(ready), 64'd0);
      end
    end
    issue(0, 32'h54, 64'd0, 8'd0, 0);
    wait_idle();

    // stray READY/VALID while idle must be ignored
    d0 = done_cnt;
    stray = 1;
    repeat (4) @(negedge clk);
    stray = 0;
    repeat (2) @(negedge clk);
    check("stray_no_done", 64'(done_cnt - d0), 64'd0);
    check("stray_ready", 64'(ready), 64'd1);
    check("stray_no_valid", {62'd0, bus.awvalid, bus.arvalid}, 64'd0);

    // randomized traffic with random slave stalls
    cfg_rand = 1;
    for (int t = 0; t < 40; t++) begin
      int region;
      logic [31:0] a;
      region = int'($urandom_range(0, 7));
      a = (region < 5 ? 32'd0 : 32'(region - 4) << 12) | (32'($urandom_range(0, 7)) << 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), 0);
      wait_idle();
    end
    cfg_rand = 0;

`ifdef AXI_TIMEOUT_EN
    // watchdog abort of a read that is never accepted
    cfg_ar_dly = 100000;
    issue(0, 32'h84, 64'd0, 8'd0, 1);
    wait_idle();
    check("tmo_latency", 64'(cyc - acc_cyc), 64'(TMO));
    check("tmo_arvalid_dropped", 64'(bus.arvalid), 64'd0);
    check("tmo_flag", 64'(tmo), 64'd1);
    cfg_ar_dly = 0;
    repeat (2) @(negedge clk);
    issue(0, 32'h84, 64'd0, 8'd0, 0);
    wait_idle();
`endif

    // reset in the middle of a stalled write
    cfg_aw_dly = 50; cfg_w_dly = 50;
    issue(1, 32'h400, 64'h77, 8'hFF, 0);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    rst = 1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_valids", {61'd0, bus.awvalid, bus.wvalid, bus.bready}, 64'd0);
    check("midrst_outputs", {59'd0, done, resp, error, tmo}, 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    @(negedge clk);
    rst = 0;
    model_rdata = '0;
    cfg_aw_dly = 0; cfg_w_dly = 0;
    repeat (5) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    issue(0, 32'h40, 64'd0, 8'd0, 0);
    wait_idle();
    repeat (2) @(negedge clk);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
